// File: rtl/hazard_forward_unit.sv
// Decode-stage bypass/interlock controller: per-port operand forwarding, pending-load scoreboard and HI/LO busy countdown.
// Optional stall performance counter is built only when HAZARD_PERF_EN is defined.
module hazard_forward_unit #(
  parameter int NSTAGE  = 2,
  parameter int NREAD   = 2,
  parameter int DW      = 32,
  parameter int MDU_LAT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        d_valid,
  input  logic [NREAD-1:0][4:0]       ra,
  input  logic [NREAD-1:0][DW-1:0]    rf_rd,
  output logic [NREAD-1:0][DW-1:0]    fwd_rd,
  input  logic [NSTAGE-1:0][4:0]      st_regw,
  input  logic [NSTAGE-1:0][DW-1:0]   st_val,
  input  logic [NSTAGE-1:0]           st_notready,
  input  logic                        ld_issue,
  input  logic [4:0]                  ld_rd,
  input  logic                        ld_done,
  input  logic [4:0]                  ld_done_rd,
  input  logic [DW-1:0]               ld_data,
  input  logic                        mdu_start,
  input  logic                        hilo_use,
  output logic                        stall,
  output logic                        mdu_busy,
  output logic [31:0]                 pending,
  output logic [31:0]                 stall_cnt
);

  localparam int CW = $clog2(MDU_LAT + 1);

  logic [31:0]      pend_q, pend_d;
  logic [CW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [NREAD-1:0] port_stall;

  // Youngest matching stage wins, then the returning load, then the scoreboard, then the register file.
  always_comb begin : fwd_mux
    logic hit;
    fwd_rd     = '0;
    port_stall = '0;
    hit        = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      hit = 1'b0;
      if (ra[p] != 5'd0) begin
        for (int i = 0; i < NSTAGE; i++) begin
          if (!hit && (st_regw[i] == ra[p])) begin
            hit = 1'b1;
            if (st_notready[i]) begin
              port_stall[p] = 1'b1;
            end else begin
              fwd_rd[p] = st_val[i];
            end
          end
        end
        if (!hit) begin
          if (ld_done && (ld_done_rd == ra[p])) begin
            fwd_rd[p] = ld_data;
          end else if (pend_q[ra[p]]) begin
            port_stall[p] = 1'b1;
          end else begin
            fwd_rd[p] = rf_rd[p];
          end
        end
      end
    end
  end

  assign mdu_busy = (mdu_cnt_q != '0);
  assign stall    = d_valid && ((|port_stall) || (hilo_use && mdu_busy));
  assign pending  = pend_q;

  // A new issue to the same register outranks the clear of the older returning load.
  always_comb begin
    pend_d = pend_q;
    if (ld_done) begin
      pend_d[ld_done_rd] = 1'b0;
    end
    if (ld_issue && (ld_rd != 5'd0)) begin
      pend_d[ld_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_start) begin
      mdu_cnt_d = CW'(MDU_LAT);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      mdu_cnt_q <= '0;
    end else begin
      pend_q    <= pend_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
